ysyx_25060170_ifu: RTL and testbench

YSYX_25060170_IFU -- requirements
Module: ysyx_25060170_ifu

---
 rtl/ysyx_25060170_ifu_pkg.sv | 15 +
 rtl/ysyx_25060170_pc_reg.sv | 31 +++
 rtl/ysyx_25060170_ifu.sv | 112 +++++++++++
 tb/tb_ysyx_25060170_ifu.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/ysyx_25060170_ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the fetch FSM state encoding and PC constants.
package ysyx_25060170_ifu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_OUT  = 2'd3
    } ifu_state_e;

    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
    localparam logic [31:0] INST_BYTES   = 32'd4;

endpackage

// File: rtl/ysyx_25060170_pc_reg.sv
// Program counter register with next-PC selection.
// Redirect beats sequential advance; otherwise the PC holds.
module ysyx_25060170_pc_reg
    import ysyx_25060170_ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        active,
    input  logic        advance,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc
);

    logic unused_bit0;
    assign unused_bit0 = redirect_pc[0];

    // PC update: redirect target, then pc+4, else hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (active && redirect_valid) begin
            pc <= {redirect_pc[31:1], 1'b0};
        end else if (advance) begin
            pc <= pc + INST_BYTES;
        end
    end

endmodule

// File: rtl/ysyx_25060170_ifu.sv
// Instruction fetch unit: one outstanding imem read at a time,
// presents the fetched word to the decoder, squashes on redirect.
module ysyx_25060170_ifu
    import ysyx_25060170_ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_arvalid,
    output logic [31:0] imem_araddr,
    input  logic        imem_arready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        imem_rready,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i
);

    ifu_state_e  state, state_d;
    logic        flush, flush_d;
    logic        inst_we;
    logic        advance;
    logic        active;
    logic [31:0] pc;
    logic [31:0] inst_q;

    assign active = (state != S_IDLE);

    ysyx_25060170_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk            (clk),
        .rst            (rst),
        .active         (active),
        .advance        (advance),
        .redirect_valid (redirect_valid_i),
        .redirect_pc    (redirect_pc_i),
        .pc             (pc)
    );

    // State, flush flag and instruction register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            flush  <= 1'b0;
            inst_q <= 32'd0;
        end else begin
            state <= state_d;
            flush <= flush_d;
            if (inst_we) begin
                inst_q <= imem_rdata;
            end
        end
    end

    // Next state and handshake outputs
    always_comb begin
        state_d      = state;
        flush_d      = flush;
        inst_we      = 1'b0;
        advance      = 1'b0;
        imem_arvalid = 1'b0;
        imem_rready  = 1'b0;
        inst_valid_o = 1'b0;
        unique case (state)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                imem_arvalid = 1'b1;
                if (imem_arready) begin
                    state_d = S_WAIT;
                    flush_d = redirect_valid_i;
                end
            end
            S_WAIT: begin
                imem_rready = 1'b1;
                if (imem_rvalid) begin
                    if (flush || redirect_valid_i) begin
                        state_d = S_REQ;
                        flush_d = 1'b0;
                    end else begin
                        inst_we = 1'b1;
                        state_d = S_OUT;
                    end
                end else if (redirect_valid_i) begin
                    flush_d = 1'b1;
                end
            end
            S_OUT: begin
                inst_valid_o = 1'b1;
                advance      = inst_ready_i;
                if (redirect_valid_i || inst_ready_i) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign imem_araddr = pc;
    assign pc_o        = pc;
    assign inst_o      = inst_q;

endmodule

// File: tb/tb_ysyx_25060170_ifu.sv
// Directed table-driven bench for the fetch unit.
// Each row: inputs for one cycle plus the outputs expected in that cycle.
module tb_ysyx_25060170_ifu;

    logic        clk;
    logic        rst;
    logic        imem_arvalid;
    logic [31:0] imem_araddr;
    logic        imem_arready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        imem_rready;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;

    int checks = 0;
    int failures = 0;

    ysyx_25060170_ifu #(
        .RESET_PC (32'h8000_0000)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .imem_arvalid     (imem_arvalid),
        .imem_araddr      (imem_araddr),
        .imem_arready     (imem_arready),
        .imem_rvalid      (imem_rvalid),
        .imem_rdata       (imem_rdata),
        .imem_rready      (imem_rready),
        .inst_valid_o     (inst_valid_o),
        .inst_ready_i     (inst_ready_i),
        .pc_o             (pc_o),
        .inst_o           (inst_o),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ar;
        logic        rv;
        logic [31:0] rd;
        logic        ir;
        logic        rdv;
        logic [31:0] rdpc;
        logic        e_arv;
        logic [31:0] e_addr;
        logic        e_rr;
        logic        e_iv;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(
        logic r, logic ar, logic rv, logic [31:0] rd,
        logic ir, logic rdv, logic [31:0] rdpc,
        logic e_arv, logic [31:0] e_addr, logic e_rr,
        logic e_iv, logic [31:0] e_pc, logic [31:0] e_inst);
        vec_t x;
        x.rst = r; x.ar = ar; x.rv = rv; x.rd = rd;
        x.ir = ir; x.rdv = rdv; x.rdpc = rdpc;
        x.e_arv = e_arv; x.e_addr = e_addr; x.e_rr = e_rr;
        x.e_iv = e_iv; x.e_pc = e_pc; x.e_inst = e_inst;
        return x;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one row at the falling edge, check, then advance a cycle
    task automatic apply(string tag, vec_t x);
        rst              = x.rst;
        imem_arready     = x.ar;
        imem_rvalid      = x.rv;
        imem_rdata       = x.rd;
        inst_ready_i     = x.ir;
        redirect_valid_i = x.rdv;
        redirect_pc_i    = x.rdpc;
        #1;
        chk({tag, " arvalid"}, {31'd0, imem_arvalid}, {31'd0, x.e_arv});
        chk({tag, " rready"}, {31'd0, imem_rready}, {31'd0, x.e_rr});
        chk({tag, " inst_valid"}, {31'd0, inst_valid_o}, {31'd0, x.e_iv});
        if (x.e_arv) chk({tag, " araddr"}, imem_araddr, x.e_addr);
        if (x.e_iv) begin
            chk({tag, " pc_o"}, pc_o, x.e_pc);
            chk({tag, " inst_o"}, inst_o, x.e_inst);
        end
        @(negedge clk);
    endtask

    localparam logic [31:0] A = 32'h8000_0000;
    localparam logic [31:0] Z = 32'h0;

    initial begin
        rst = 1'b1;
        imem_arready = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = Z;
        inst_ready_i = 1'b0;
        redirect_valid_i = 1'b0;
        redirect_pc_i = Z;

        //            rst ar rv rdata          ir rdv rdpc          arv addr          rr iv pc            inst
        tbl.push_back(v(1, 0, 0, Z,             0, 0, Z,             0, Z,             0, 0, Z,            Z));
        tbl.push_back(v(0, 0, 0, Z,             0, 0, Z,             0, Z,             0, 0, Z,            Z));
        tbl.push_back(v(0, 1, 0, Z,             0, 0, Z,             1, A,             0, 0, Z,            Z));
        tbl.push_back(v(0, 0, 1, 32'h00000413,  0, 0, Z,             0, Z,             1, 0, Z,            Z));
        tbl.push_back(v(0, 0, 0, Z,             1, 0, Z,             0, Z,             0, 1, A,            32'h00000413));
        tbl.push_back(v(0, 1, 0, Z,             0, 0, Z,             1, A+4,           0, 0, Z,            Z));
        tbl.push_back(v(0, 0, 0, Z,             0, 0, Z,             0, Z,             1, 0, Z,            Z));
        tbl.push_back(v(0, 0, 1, 32'h00100093,  0, 0, Z,             0, Z,             1, 0, Z,            Z));
        for (int i = 0; i < 4; i++)
            tbl.push_back(v(0, 0, 0, Z,         0, 0, Z,             0, Z,             0, 1, A+4,          32'h00100093));
        tbl.push_back(v(0, 0, 0, Z,             1, 0, Z,             0, Z,             0, 1, A+4,          32'h00100093));
        tbl.push_back(v(0, 1, 0, Z,             0, 0, Z,             1, A+8,           0, 0, Z,            Z));
        tbl.push_back(v(0, 0, 0, Z,             0, 1, 32'h8000_0101, 0, Z,             1, 0, Z,            Z));
        tbl.push_back(v(0, 0, 1, 32'hDEADBEEF,  0, 0, Z,             0, Z,             1, 0, Z,            Z));
        tbl.push_back(v(0, 1, 0, Z,             0, 0, Z,             1, 32'h8000_0100, 0, 0, Z,            Z));
        tbl.push_back(v(0, 0, 1, 32'h00200113,  0, 0, Z,             0, Z,             1, 0, Z,            Z));
        tbl.push_back(v(0, 0, 0, Z,             1, 1, 32'h8000_0200, 0, Z,             0, 1, 32'h8000_0100, 32'h00200113));
        tbl.push_back(v(0, 0, 0, Z,             0, 1, 32'h8000_0300, 1, 32'h8000_0200, 0, 0, Z,            Z));
        tbl.push_back(v(0, 1, 0, Z,             0, 1, 32'h8000_0400, 1, 32'h8000_0300, 0, 0, Z,            Z));
        tbl.push_back(v(0, 0, 1, 32'hBAD0BAD0,  0, 0, Z,             0, Z,             1, 0, Z,            Z));
        tbl.push_back(v(0, 1, 0, Z,             0, 0, Z,             1, 32'h8000_0400, 0, 0, Z,            Z));
        tbl.push_back(v(0, 0, 1, 32'h00300193,  0, 0, Z,             0, Z,             1, 0, Z,            Z));
        tbl.push_back(v(0, 0, 0, Z,             0, 1, 32'h8000_0500, 0, Z,             0, 1, 32'h8000_0400, 32'h00300193));
        tbl.push_back(v(0, 0, 1, 32'h11111111,  0, 0, Z,             1, 32'h8000_0500, 0, 0, Z,            Z));
        tbl.push_back(v(0, 1, 0, Z,             0, 0, Z,             1, 32'h8000_0500, 0, 0, Z,            Z));
        tbl.push_back(v(0, 0, 1, 32'h00400213,  0, 0, Z,             0, Z,             1, 0, Z,            Z));
        tbl.push_back(v(0, 0, 0, Z,             1, 0, Z,             0, Z,             0, 1, 32'h8000_0500, 32'h00400213));
        tbl.push_back(v(0, 1, 0, Z,             0, 0, Z,             1, 32'h8000_0504, 0, 0, Z,            Z));

        #1;
        for (int i = 0; i < tbl.size(); i++)
            apply($sformatf("row%0d", i), tbl[i]);

        // Now in WAIT: pulse reset between clock edges
        imem_arready = 1'b0;
        imem_rvalid  = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst arvalid", {31'd0, imem_arvalid}, Z);
        chk("async_rst rready", {31'd0, imem_rready}, Z);
        chk("async_rst inst_valid", {31'd0, inst_valid_o}, Z);
        @(negedge clk);
        apply("rst_hold", v(1, 0, 1, 32'hCAFEF00D, 0, 0, Z, 0, Z, 0, 0, Z, Z));
        apply("rst_rel",  v(0, 0, 0, Z, 0, 0, Z, 0, Z, 0, 0, Z, Z));
        for (int i = 0; i < 5; i++)
            apply($sformatf("ar_stall%0d", i), v(0, 0, 0, Z, 0, 0, Z, 1, A, 0, 0, Z, Z));
        apply("ar_accept", v(0, 1, 0, Z, 0, 0, Z, 1, A, 0, 0, Z, Z));
        apply("r_data",    v(0, 0, 1, 32'h00500293, 0, 0, Z, 0, Z, 1, 0, Z, Z));
        apply("out2",      v(0, 0, 0, Z, 1, 0, Z, 0, Z, 0, 1, A, 32'h00500293));
        apply("next_req",  v(0, 0, 0, Z, 0, 0, Z, 1, A+4, 0, 0, Z, Z));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
